// File: rtl/data_consumer_pkg.sv
// Shared types and helpers for the counter-pattern consumer.
// Pattern runs 0..max and wraps back to 0.
package data_consumer_pkg;

  localparam int DC_N       = 32;
  localparam int DC_MAX_VAL = 255;
  localparam int DC_CW      = 32;

  typedef enum logic {
    SYNC  = 1'b0,
    CHECK = 1'b1
  } dc_state_e;

  function automatic logic [63:0] dc_next(
    input logic [63:0] v,
    input logic [63:0] max_val
  );
    return (v >= max_val) ? 64'd0 : v + 64'd1;
  endfunction

endpackage

// File: rtl/data_consumer_sat_counter.sv
// Up-counter that sticks at all-ones.
// Clear wins over increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/data_consumer.sv
// Drains a FIFO carrying the wrap-around counter pattern
// and checks each word against the expected sequence.
module data_consumer
  import data_consumer_pkg::*;
#(
  parameter int          N       = DC_N,
  parameter int unsigned MAX_VAL = DC_MAX_VAL,
  parameter int          CW      = DC_CW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          clr_i,
  input  logic          fifo_empty_i,
  input  logic [N-1:0]  fifo_data_i,
  output logic          fifo_rd_o,
  output logic          locked_o,
  output logic          err_o,
  output logic [CW-1:0] word_cnt_o,
  output logic [CW-1:0] err_cnt_o,
  output logic [N-1:0]  first_exp_o,
  output logic [N-1:0]  first_got_o
);

  localparam logic [N-1:0] MAXV = N'(MAX_VAL);

  dc_state_e      state;
  logic           rd_vld;
  logic [N-1:0]   exp_q;
  logic           in_range;
  logic           match;
  logic           take;
  logic           bad;
  logic [N-1:0]   nxt;
  logic [N-1:0]   cap_exp;

  assign fifo_rd_o = en_i & ~fifo_empty_i
                   & ~clr_i & ~rst_i;

  assign in_range = (fifo_data_i <= MAXV);
  assign match    = (fifo_data_i == exp_q);
  assign take     = rd_vld & ~clr_i;
  assign bad      = take & ((state == SYNC)
                  ? ~in_range : ~match);
  assign nxt      = N'(dc_next(64'(fifo_data_i),
                               64'(MAXV)));
  // No expectation exists before lock; report the wrap value.
  assign cap_exp  = (state == SYNC) ? MAXV : exp_q;
  assign locked_o = (state == CHECK);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= SYNC;
      rd_vld      <= 1'b0;
      exp_q       <= '0;
      err_o       <= 1'b0;
      first_exp_o <= '0;
      first_got_o <= '0;
    end else begin
      rd_vld <= fifo_rd_o;
      if (clr_i) begin
        state       <= SYNC;
        err_o       <= 1'b0;
        first_exp_o <= '0;
        first_got_o <= '0;
      end else if (rd_vld) begin
        unique case (state)
          SYNC: begin
            if (in_range) begin
              exp_q <= nxt;
              state <= CHECK;
            end
          end
          CHECK: begin
            exp_q <= nxt;
            if (!match && !in_range) begin
              state <= SYNC;
            end
          end
        endcase
        if (bad) begin
          err_o <= 1'b1;
          if (!err_o) begin
            first_exp_o <= cap_exp;
            first_got_o <= fifo_data_i;
          end
        end
      end
    end
  end

  sat_counter #(.W(CW)) u_word_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (take),
    .clr   (clr_i),
    .cnt   (word_cnt_o)
  );

  sat_counter #(.W(CW)) u_err_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (bad),
    .clr   (clr_i),
    .cnt   (err_cnt_o)
  );

endmodule

// File: tb/tb_data_consumer.sv
// Bench for data_consumer: FIFO model, word-level reference
// checker, and a narrow-counter twin for saturation.
module tb_data_consumer;

  localparam int MAXV = 255;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic        clr_i;
  logic        fifo_empty_i;
  logic [31:0] fifo_data_i;

  logic        fifo_rd_o, locked_o, err_o;
  logic [31:0] word_cnt_o, err_cnt_o;
  logic [31:0] first_exp_o, first_got_o;

  logic        rd4, lock4, err4;
  logic [3:0]  wc4, ec4;
  logic [31:0] fe4, fg4;

  data_consumer dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .clr_i        (clr_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_data_i  (fifo_data_i),
    .fifo_rd_o    (fifo_rd_o),
    .locked_o     (locked_o),
    .err_o        (err_o),
    .word_cnt_o   (word_cnt_o),
    .err_cnt_o    (err_cnt_o),
    .first_exp_o  (first_exp_o),
    .first_got_o  (first_got_o)
  );

  data_consumer #(.CW(4)) dut4 (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .clr_i        (clr_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_data_i  (fifo_data_i),
    .fifo_rd_o    (rd4),
    .locked_o     (lock4),
    .err_o        (err4),
    .word_cnt_o   (wc4),
    .err_cnt_o    (ec4),
    .first_exp_o  (fe4),
    .first_got_o  (fg4)
  );

  always #5 clk_i = ~clk_i;

  logic [31:0] q[$];
  logic [31:0] last_push;
  bit          m_vld, m_lock, m_err;
  longint      m_exp, m_words, m_errs;
  longint      m_fe, m_fg;
  int          errors = 0;
  int          checks = 0;
  int          pushed;

  function automatic longint nxt(longint v);
    return (v >= MAXV) ? 0 : v + 1;
  endfunction

  function automatic longint sat(longint v, int w);
    longint top;
    top = (64'sd1 <<< w) - 1;
    return (v > top) ? top : v;
  endfunction

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_vld = 0; m_lock = 0; m_err = 0;
    m_exp = 0; m_words = 0; m_errs = 0;
    m_fe = 0; m_fg = 0;
  endtask

  task automatic model_err(longint e, longint g);
    m_errs++;
    if (!m_err) begin
      m_fe = e;
      m_fg = g;
    end
    m_err = 1;
  endtask

  // Word-level rules: lock on any in-range word, then
  // follow the count and resync after every mismatch.
  task automatic model_word(longint d);
    m_words++;
    if (!m_lock) begin
      if (d <= MAXV) begin
        m_exp  = nxt(d);
        m_lock = 1;
      end else begin
        model_err(MAXV, d);
      end
    end else if (d == m_exp) begin
      m_exp = nxt(d);
    end else begin
      model_err(m_exp, d);
      m_exp = nxt(d);
      if (d > MAXV) m_lock = 0;
    end
  endtask

  task automatic check_all();
    chk("locked", locked_o, m_lock);
    chk("err", err_o, m_err);
    chk("word_cnt", word_cnt_o, sat(m_words, 32));
    chk("err_cnt", err_cnt_o, sat(m_errs, 32));
    chk("first_exp", first_exp_o, m_fe);
    chk("first_got", first_got_o, m_fg);
    chk("word_cnt4", wc4, sat(m_words, 4));
    chk("err_cnt4", ec4, sat(m_errs, 4));
    chk("first_exp4", fe4, m_fe);
    chk("first_got4", fg4, m_fg);
  endtask

  task automatic push(logic [31:0] v);
    q.push_back(v);
    last_push = v;
    pushed++;
  endtask

  // Called just after a falling edge; returns on the next one.
  task automatic cycle(bit en, bit clr);
    bit exp_rd;
    en_i = en;
    clr_i = clr;
    fifo_empty_i = (q.size() == 0);
    exp_rd = en && (q.size() != 0) && !clr;
    #1;
    chk("fifo_rd", fifo_rd_o, exp_rd);
    chk("fifo_rd4", rd4, exp_rd);
    @(posedge clk_i);
    if (clr) model_clear();
    else if (m_vld) model_word(fifo_data_i);
    m_vld = exp_rd;
    #1;
    if (exp_rd) fifo_data_i = q.pop_front();
    check_all();
    @(negedge clk_i);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 3000) begin
      cycle(1, 0);
      guard++;
    end
    chk("drain_timeout", 64'(q.size()), 0);
    cycle(1, 0);
    cycle(1, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    pushed = 0;
    last_push = 0;
    rst_i = 1; en_i = 1; clr_i = 0;
    fifo_empty_i = 0; fifo_data_i = '0;
    #2;
    chk("rst_rd", fifo_rd_o, 0);
    check_all();
    @(negedge clk_i);
    rst_i = 0;

    // Clean stream with wrap.
    for (int v = 0; v <= 255; v++) push(v);
    for (int v = 0; v <= 10; v++) push(v);
    drain();
    chk("clean_words", word_cnt_o, 267);
    chk("clean_errs", err_cnt_o, 0);
    chk("clean_lock", locked_o, 1);

    // Start mid-pattern.
    cycle(0, 1);
    for (int v = 100; v <= 120; v++) push(v);
    drain();
    chk("mid_errs", err_cnt_o, 0);
    chk("mid_lock", locked_o, 1);

    // Single skip.
    cycle(0, 1);
    push(4); push(5); push(7); push(8); push(9);
    drain();
    chk("skip_errs", err_cnt_o, 1);
    chk("skip_fexp", first_exp_o, 6);
    chk("skip_fgot", first_got_o, 7);
    chk("skip_lock", locked_o, 1);

    // Out-of-range word while unlocked.
    cycle(0, 1);
    push(300); push(3); push(4);
    drain();
    chk("oor_errs", err_cnt_o, 1);
    chk("oor_fexp", first_exp_o, 255);
    chk("oor_fgot", first_got_o, 300);
    chk("oor_lock", locked_o, 1);

    // Wrap boundaries.
    cycle(0, 1);
    for (int v = 250; v <= 255; v++) push(v);
    push(0); push(1); push(2);
    drain();
    chk("wrap_ok_errs", err_cnt_o, 0);
    cycle(0, 1);
    push(254); push(255); push(256);
    drain();
    chk("wrap_bad_errs", err_cnt_o, 1);
    chk("wrap_bad_fexp", first_exp_o, 0);
    chk("wrap_bad_lock", locked_o, 0);

    // Random gaps, en toggling, occasional corruption.
    cycle(0, 1);
    pushed = 0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) push($urandom());
        else if (r == 1) push($urandom_range(0, 400));
        else push(32'(nxt(last_push)));
      end
      cycle(((i / 3) % 2) == 0, 0);
    end
    drain();
    chk("rand_words", word_cnt_o, pushed);

    // Clear coincident with a valid word.
    cycle(0, 1);
    push(10); push(11); push(12);
    cycle(1, 0);
    cycle(1, 1);
    chk("clr_words", word_cnt_o, 0);
    chk("clr_lock", locked_o, 0);
    drain();
    chk("clr_after", word_cnt_o, 2);

    // Asynchronous reset mid-stream.
    for (int v = 50; v <= 70; v++) push(v);
    repeat (5) cycle(1, 0);
    #2;
    rst_i = 1;
    #1;
    model_clear();
    chk("arst_rd", fifo_rd_o, 0);
    check_all();
    @(negedge clk_i);
    rst_i = 0;
    drain();
    chk("arst_errs", err_cnt_o, 0);

    // Saturation of the narrow counters.
    cycle(0, 1);
    repeat (20) push(300);
    drain();
    chk("sat_err4", ec4, 15);
    chk("sat_err", err_cnt_o, 20);
    chk("sat_fexp4", fe4, 255);
    chk("sat_fgot4", fg4, 300);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
